// File: rtl/mcc_mem_responder_pkg.sv
// rtl/mcc_mem_responder_pkg.sv - shared memory widths and responder state encoding
package mcc_mem_responder_pkg;

    localparam int MEMORY_ADDR_WIDTH = 32;
    localparam int MEMORY_DATA_WIDTH = 32;

    // Responder sequencing: accept, count wait states, present completion
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mcc_sp_ram.sv
// rtl/mcc_sp_ram.sv - synchronous single-port RAM with one-cycle registered read
module mcc_sp_ram
    import mcc_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = MEMORY_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    // Write stores the word; read registers it. rdata holds across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mcc_mem_responder.sv
// rtl/mcc_mem_responder.sv - wait-stated memory target for the MCC memory port
module mcc_mem_responder
    import mcc_mem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = MEMORY_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = MEMORY_DATA_WIDTH,
    parameter int                    DEPTH_LOG2  = 10,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] BAD_DATA    = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mem_en,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_rdy,
    output logic                  mem_err,
    output logic                  busy
);

    resp_state_t           state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  rd_seen;
    logic                  rd_bad;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  addr_ok;
    logic                  last_wait;
    logic                  ram_en;

    // No wrap/aliasing: any set bit above the array index makes the access invalid
    assign addr_ok   = (lat_addr >> DEPTH_LOG2) == '0;
    // RAM is driven during the final wait cycle so its registered read lands with mem_rdy
    assign last_wait = (state == ST_WAIT) && (cnt == 4'd0);
    assign ram_en    = last_wait && addr_ok;

    mcc_sp_ram #(
        .ADDR_BITS  (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (lat_we),
        .addr  (lat_addr[DEPTH_LOG2-1:0]),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    // Request sequencing: latch in IDLE, count down in WAIT, one-cycle completion in RESP
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            mem_rdy   <= 1'b0;
            mem_err   <= 1'b0;
            busy      <= 1'b0;
            rd_seen   <= 1'b0;
            rd_bad    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_en) begin
                        lat_addr  <= mem_addr;
                        lat_we    <= mem_we;
                        lat_wdata <= mem_wr_data;
                        cnt       <= 4'(WAIT_CYCLES);
                        busy      <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        mem_rdy <= 1'b1;
                        mem_err <= !addr_ok;
                        state   <= ST_RESP;
                        if (!lat_we) begin
                            rd_seen <= 1'b1;
                            rd_bad  <= !addr_ok;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    mem_rdy <= 1'b0;
                    mem_err <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data is zero until the first read, then reflects the most recent read only
    assign mem_rd_data = !rd_seen ? '0 : (rd_bad ? BAD_DATA : ram_rdata);

endmodule

// File: tb/tb_mcc_mem_responder.sv
// tb/tb_mcc_mem_responder.sv - scoreboard bench for mcc_mem_responder
module tb_mcc_mem_responder;

    localparam int          DL  = 10;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic              clk  = 1'b0;
    logic              rstn = 1'b0;
    logic [1:0]        en;
    logic [1:0]        we;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wd;
    logic [1:0][31:0]  rd;
    logic [1:0]        rdy;
    logic [1:0]        err;
    logic [1:0]        busy;

    typedef struct {
        int          inst;
        int          rdy_cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [longint];
    logic [31:0] last_rd [2];
    int          wcyc [2];
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    bit          kept   = 1'b0;
    logic [1:0]  prev_rdy = 2'b00;

    mcc_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(DL), .WAIT_CYCLES(2), .BAD_DATA(BAD)
    ) u_dut2 (
        .clk(clk), .rstn(rstn), .mem_en(en[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wr_data(wd[0]), .mem_rd_data(rd[0]), .mem_rdy(rdy[0]), .mem_err(err[0]), .busy(busy[0])
    );

    mcc_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(DL), .WAIT_CYCLES(0), .BAD_DATA(BAD)
    ) u_dut0 (
        .clk(clk), .rstn(rstn), .mem_en(en[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wr_data(wd[1]), .mem_rd_data(rd[1]), .mem_rdy(rdy[1]), .mem_err(err[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rdy[i]) begin
                chk("rdy_single_cycle", {31'd0, prev_rdy[i]}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: inst %0d pulsed with no request outstanding", i);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdy_inst", i, e.inst);
                    chk("rdy_cycle", cyc, e.rdy_cyc);
                    chk("mem_err", {31'd0, err[i]}, {31'd0, e.err});
                    chk("mem_rd_data", rd[i], e.data);
                end
            end else begin
                chk("err_without_rdy", {31'd0, err[i]}, 32'd0);
            end
        end
        prev_rdy = rdy;
    end

    // One access from instance i; b2b follows from the previous call having kept mem_en high
    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit scramble, input bit keep);
        exp_t   e;
        longint key;
        int     acc;
        int     n;
        bit     b2b;
        b2b = kept;
        if (!b2b) begin
            @(negedge clk);
            chk("busy_idle", {31'd0, busy[i]}, 32'd0);
            acc = cyc + 1;
        end else begin
            acc = cyc + 2;
        end
        key       = (longint'(i) << 32) | longint'(a);
        e.inst    = i;
        e.rdy_cyc = acc + wcyc[i] + 1;
        if ((a >> DL) != 0) begin
            e.err = 1'b1;
            if (w) begin
                e.data = last_rd[i];
            end else begin
                e.data     = BAD;
                last_rd[i] = BAD;
            end
        end else begin
            e.err = 1'b0;
            if (w) begin
                mdl[key] = d;
                e.data   = last_rd[i];
            end else begin
                e.data     = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
                last_rd[i] = e.data;
            end
        end
        exp_q.push_back(e);
        en[i]   = 1'b1;
        we[i]   = w;
        addr[i] = a;
        wd[i]   = d;
        n = 0;
        if (scramble && !b2b) begin
            @(negedge clk);
            n++;
            chk("busy_in_wait", {31'd0, busy[i]}, 32'd1);
            en[i]   = 1'b0;
            we[i]   = ~w;
            addr[i] = $urandom;
            wd[i]   = $urandom;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[i] && n < 40);
        if (!rdy[i]) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: inst %0d addr %h never completed", i, a);
            exp_q.delete();
        end
        if (!keep) en[i] = 1'b0;
        kept = keep;
    endtask

    initial begin
        logic [31:0] a;
        wcyc[0]    = 2;
        wcyc[1]    = 0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        en   = '0;
        we   = '0;
        addr = '0;
        wd   = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdy", {31'd0, rdy[i]}, 32'd0);
            chk("rst_err", {31'd0, err[i]}, 32'd0);
            chk("rst_busy", {31'd0, busy[i]}, 32'd0);
            chk("rst_rd_data", rd[i], 32'd0);
        end
        rstn = 1'b1;

        // Basic write then read
        issue(0, 1'b1, 32'd5, 32'h1234_5678, 1'b0, 1'b0);
        issue(0, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);

        // Fill a small window so random reads have known contents
        for (int k = 0; k < 32; k++)
            issue(0, 1'b1, 32'(k), $urandom, 1'b0, (k != 31) && 1'($urandom_range(0, 1)));

        // Back-to-back reads held through the completion pulse
        issue(0, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1);
        issue(0, 1'b0, 32'd4, 32'd0, 1'b0, 1'b1);
        issue(0, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);

        // Out-of-range read/write, then confirm no aliasing onto address 0
        issue(0, 1'b0, 32'h0000_0400, 32'd0, 1'b0, 1'b0);
        issue(0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 1'b0, 1'b0);
        issue(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Inputs disturbed during WAIT
        issue(0, 1'b1, 32'd9, 32'h0BAD_F00D, 1'b1, 1'b0);
        issue(0, 1'b0, 32'd9, 32'd0, 1'b1, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_0400) : 32'($urandom_range(0, 31));
            issue(0, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
                  (k != 59) && 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a write to address 7
        issue(0, 1'b1, 32'd7, 32'hA5A5_A5A5, 1'b0, 1'b0);
        @(negedge clk);
        en[0]   = 1'b1;
        we[0]   = 1'b1;
        addr[0] = 32'd7;
        wd[0]   = 32'h1111_2222;
        @(negedge clk);
        chk("busy_before_abort", {31'd0, busy[0]}, 32'd1);
        en[0] = 1'b0;
        rstn  = 1'b0;
        #1;
        chk("abort_rdy", {31'd0, rdy[0]}, 32'd0);
        chk("abort_busy", {31'd0, busy[0]}, 32'd0);
        chk("abort_rd_data", rd[0], 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(negedge clk);
        rstn = 1'b1;
        issue(0, 1'b0, 32'd7, 32'd0, 1'b0, 1'b0);

        // Zero wait states at the top of the array
        issue(1, 1'b1, 32'd1023, 32'h5A5A_0001, 1'b0, 1'b0);
        issue(1, 1'b0, 32'd1023, 32'd0, 1'b0, 1'b0);
        issue(1, 1'b1, 32'd1023, 32'h0F0F_7777, 1'b0, 1'b1);
        issue(1, 1'b0, 32'd1023, 32'd0, 1'b0, 1'b1);
        issue(1, 1'b0, 32'h0000_0400, 32'd0, 1'b0, 1'b0);
        issue(1, 1'b0, 32'd1023, 32'd0, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
